// File: rtl/mux32_serializer_pkg.sv
// Shared types and helpers for the 32-bit word serializer.
package mux32_serializer_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // First bit index emitted for a word.
  function automatic logic [SEL_W-1:0] start_idx(input bit lsb_first);
    return lsb_first ? SEL_W'(0) : SEL_W'(WORD_W - 1);
  endfunction

  // Final bit index emitted for a word; the strobe at this index carries ser_last.
  function automatic logic [SEL_W-1:0] end_idx(input bit lsb_first);
    return lsb_first ? SEL_W'(WORD_W - 1) : SEL_W'(0);
  endfunction

endpackage

// File: rtl/mux32_serializer_mux.sv
// 32:1 bit-select multiplexer driven by the serializer's select counter.
module mux32to1
  import mux32_serializer_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic [WORD_W-1:0] in,
  output logic              out
);

  assign out = in[sel];

endmodule

// File: rtl/mux32_serializer.sv
// Latches a 32-bit word and emits it one bit per DIV-cycle period through a
// valid/ready serial port, stepping the mux select across all 32 positions.
module mux32_serializer
  import mux32_serializer_pkg::*;
#(
  parameter int DIV       = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [SEL_W-1:0] SEL_START = start_idx(LSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_END   = end_idx(LSB_FIRST);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic shifting;
  logic at_end;
  logic xfer;
  logic accept;
  logic mux_bit;

  assign shifting  = (state_q == SHIFT);
  assign at_end    = (sel_q == SEL_END);
  // The strobe is a pure function of registers so it drops with rst_n alone.
  assign ser_valid = shifting && (cnt_q == CNT_MAX);
  assign ser_last  = ser_valid && at_end;
  assign xfer      = ser_valid && ser_ready;
  // A new word may land on the same edge the final bit is taken.
  assign in_ready  = !shifting || (ser_last && ser_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = shifting;
  assign sel       = sel_q;
  assign ser_data  = shifting && mux_bit;

  mux32to1 u_mux (
    .sel (sel_q),
    .in  (word_q),
    .out (mux_bit)
  );

  // Next-state logic for the FSM, bit-period divider and select counter.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          word_d  = in_data;
          sel_d   = SEL_START;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          cnt_d = '0;
          if (at_end) begin
            if (accept) begin
              word_d = in_data;
              sel_d  = SEL_START;
            end else begin
              state_d = IDLE;
            end
          end else if (LSB_FIRST) begin
            sel_d = sel_q + SEL_W'(1);
          end else begin
            sel_d = sel_q - SEL_W'(1);
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, word, select and divider registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= SEL_START;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux32_serializer.sv
// Bench for mux32_serializer: three configurations driven from one clock.
module tb_mux32_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data   [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [4:0]  sel       [3];
  logic        ser_data  [3];
  logic        ser_valid [3];
  logic        ser_ready [3];
  logic        ser_last  [3];
  logic        busy      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux32_serializer #(.DIV(1), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .sel(sel[0]), .ser_data(ser_data[0]),
    .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]), .ser_last(ser_last[0]),
    .busy(busy[0]));

  mux32_serializer #(.DIV(1), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .sel(sel[1]), .ser_data(ser_data[1]),
    .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]), .ser_last(ser_last[1]),
    .busy(busy[1]));

  mux32_serializer #(.DIV(4), .LSB_FIRST(1'b1)) u_div4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .sel(sel[2]), .ser_data(ser_data[2]),
    .ser_valid(ser_valid[2]), .ser_ready(ser_ready[2]), .ser_last(ser_last[2]),
    .busy(busy[2]));

  function automatic int div_of(input int inst);
    return (inst == 2) ? 4 : 1;
  endfunction

  function automatic bit lsb_of(input int inst);
    return (inst != 1);
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31 - i];
    return r;
  endfunction

  // Expected order of emitted bits, packed so entry k is the k-th strobe.
  function automatic logic [31:0] stream_of(input int inst, input logic [31:0] w);
    return lsb_of(inst) ? w : rev32(w);
  endfunction

  // Reference model: bit k of a word is strobed once DIV cycles have elapsed
  // since the accept or the previous transfer, and is held until taken.
  // mode 0: ready held high; 1: random ready; 2: 5-cycle stall at the 5th bit.
  task automatic run_stream(input int inst, input logic [31:0] w0, input logic [31:0] w1,
                            input bit two, input int mode,
                            output logic [31:0] cap, output int cyc);
    int          div, k, wait_c, nw, stall, idx;
    bit          lsb, done, rdy, exp_v;
    logic [31:0] word;
    div = div_of(inst);
    lsb = lsb_of(inst);
    cap = '0;
    cyc = 0;
    @(negedge clk);
    in_data[inst]   = w0;
    in_valid[inst]  = 1'b1;
    ser_ready[inst] = 1'b1;
    #1;
    checks++;
    if (in_ready[inst] !== 1'b1) begin
      errors++; $display("FAIL accept_ready inst%0d: got %b expected 1", inst, in_ready[inst]);
    end
    @(posedge clk);
    word = w0; nw = 0; k = 0; wait_c = 0; stall = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (two && nw == 0) begin
        in_data[inst]  = w1;
        in_valid[inst] = 1'b1;
      end else begin
        in_valid[inst] = 1'b0;
        in_data[inst]  = $urandom;
      end
      case (mode)
        1: rdy = ($urandom_range(0, 3) != 0);
        2: if (k == 4 && stall < 5) begin rdy = 1'b0; stall++; end else rdy = 1'b1;
        default: rdy = 1'b1;
      endcase
      ser_ready[inst] = rdy;
      #1;
      wait_c++;
      cyc++;
      idx   = lsb ? k : 31 - k;
      exp_v = (wait_c >= div);
      checks++;
      if (ser_valid[inst] !== exp_v) begin
        errors++; $display("FAIL ser_valid inst%0d word%0d k=%0d: got %b expected %b", inst, nw, k, ser_valid[inst], exp_v);
      end
      checks++;
      if (sel[inst] !== 5'(idx)) begin
        errors++; $display("FAIL sel inst%0d word%0d k=%0d: got %0d expected %0d", inst, nw, k, sel[inst], idx);
      end
      checks++;
      if (busy[inst] !== 1'b1) begin
        errors++; $display("FAIL busy inst%0d k=%0d: got %b expected 1", inst, k, busy[inst]);
      end
      checks++;
      if (ser_last[inst] !== (exp_v && k == 31)) begin
        errors++; $display("FAIL ser_last inst%0d word%0d k=%0d: got %b expected %b", inst, nw, k, ser_last[inst], exp_v && k == 31);
      end
      checks++;
      if (in_ready[inst] !== (exp_v && k == 31 && rdy)) begin
        errors++; $display("FAIL in_ready inst%0d word%0d k=%0d: got %b expected %b", inst, nw, k, in_ready[inst], exp_v && k == 31 && rdy);
      end
      checks++;
      if (ser_data[inst] !== word[idx]) begin
        errors++; $display("FAIL ser_data inst%0d word%0d k=%0d: got %b expected %b", inst, nw, k, ser_data[inst], word[idx]);
      end
      if (exp_v && rdy) begin
        if (nw == 0) cap[k] = ser_data[inst];
        k++;
        wait_c = 0;
        if (k == 32) begin
          if (two && nw == 0) begin
            nw = 1; word = w1; k = 0;
          end else begin
            done = 1'b1;
          end
        end
      end
      if (cyc > 5000) begin
        errors++; $display("FAIL timeout inst%0d: got %0d cycles expected at most 5000", inst, cyc);
        done = 1'b1;
      end
    end
    @(negedge clk);
    in_valid[inst]  = 1'b0;
    ser_ready[inst] = 1'b1;
    #1;
    checks++;
    if (busy[inst] !== 1'b0 || ser_valid[inst] !== 1'b0 || ser_data[inst] !== 1'b0 || in_ready[inst] !== 1'b1) begin
      errors++;
      $display("FAIL idle_after inst%0d: got busy=%b valid=%b data=%b ready=%b expected 0,0,0,1",
               inst, busy[inst], ser_valid[inst], ser_data[inst], in_ready[inst]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || ser_valid[i] !== 1'b0 || ser_data[i] !== 1'b0 ||
          ser_last[i] !== 1'b0 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got ready=%b valid=%b data=%b last=%b busy=%b expected 1,0,0,0,0",
                 i, in_ready[i], ser_valid[i], ser_data[i], ser_last[i], busy[i]);
      end
      checks++;
      if (sel[i] !== (lsb_of(i) ? 5'd0 : 5'd31)) begin
        errors++; $display("FAIL reset_sel inst%0d: got %0d expected %0d", i, sel[i], lsb_of(i) ? 0 : 31);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [31:0] cap;
    int          cyc;
    run_stream(0, 32'hDEADBEEF, 32'h0, 1'b0, 0, cap, cyc);
    checks++;
    if (cap[7:0] !== 8'hEF) begin
      errors++; $display("FAIL lsb_first8: got %b expected 11101111", cap[7:0]);
    end
    checks++;
    if (cap !== 32'hDEADBEEF || cap[31] !== 1'b1) begin
      errors++; $display("FAIL lsb_stream: got %h expected deadbeef", cap);
    end
    checks++;
    if (cyc !== 32) begin
      errors++; $display("FAIL lsb_duration: got %0d expected 32", cyc);
    end
  endtask

  task automatic test_msb_first();
    logic [31:0] cap;
    int          cyc;
    run_stream(1, 32'hDEADBEEF, 32'h0, 1'b0, 0, cap, cyc);
    checks++;
    if (cap[3:0] !== 4'b1011) begin
      errors++; $display("FAIL msb_first4: got %b expected 1011 (k3..k0)", cap[3:0]);
    end
    checks++;
    if (cap !== 32'hF77DB57B) begin
      errors++; $display("FAIL msb_stream: got %h expected f77db57b", cap);
    end
  endtask

  task automatic test_div4();
    logic [31:0] cap;
    int          cyc;
    run_stream(2, 32'hDEADBEEF, 32'h0, 1'b0, 0, cap, cyc);
    checks++;
    if (cyc !== 128) begin
      errors++; $display("FAIL div4_duration: got %0d expected 128", cyc);
    end
    checks++;
    if (cap !== 32'hDEADBEEF) begin
      errors++; $display("FAIL div4_stream: got %h expected deadbeef", cap);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap;
    int          cyc;
    run_stream(0, 32'hDEADBEEF, 32'h00000001, 1'b1, 0, cap, cyc);
    checks++;
    if (cyc !== 64) begin
      errors++; $display("FAIL b2b_gap: got %0d cycles expected 64", cyc);
    end
    run_stream(2, 32'h12345678, 32'h80000001, 1'b1, 0, cap, cyc);
    checks++;
    if (cyc !== 256) begin
      errors++; $display("FAIL b2b_div4_gap: got %0d cycles expected 256", cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] cap;
    int          cyc;
    run_stream(0, 32'hDEADBEEF, 32'h0, 1'b0, 2, cap, cyc);
    checks++;
    if (cyc !== 37) begin
      errors++; $display("FAIL stall_duration: got %0d expected 37", cyc);
    end
    checks++;
    if (cap !== 32'hDEADBEEF) begin
      errors++; $display("FAIL stall_stream: got %h expected deadbeef", cap);
    end
  endtask

  task automatic test_random();
    logic [31:0] cap, w0, w1;
    int          cyc, inst;
    for (int r = 0; r < 9; r++) begin
      inst = r % 3;
      w0   = $urandom;
      w1   = $urandom;
      run_stream(inst, w0, w1, (r >= 6), 1, cap, cyc);
      checks++;
      if (cap !== stream_of(inst, w0)) begin
        errors++; $display("FAIL random_stream inst%0d: got %h expected %h", inst, cap, stream_of(inst, w0));
      end
    end
  endtask

  task automatic test_reset_midword();
    bit saw_last;
    bit found;
    saw_last = 1'b0;
    found    = 1'b0;
    @(negedge clk);
    in_data[0]   = 32'hDEADBEEF;
    in_valid[0]  = 1'b1;
    ser_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      #1;
      if (ser_last[0] === 1'b1) saw_last = 1'b1;
      if (sel[0] === 5'd10 && busy[0] === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midword_reach: got sel=%0d expected 10", sel[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ser_valid[0] !== 1'b0 || busy[0] !== 1'b0 || ser_data[0] !== 1'b0 ||
        ser_last[0] !== 1'b0 || in_ready[0] !== 1'b1 || sel[0] !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b busy=%b data=%b last=%b ready=%b sel=%0d expected 0,0,0,0,1,0",
               ser_valid[0], busy[0], ser_data[0], ser_last[0], in_ready[0], sel[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (ser_last[0] === 1'b1) saw_last = 1'b1;
      checks++;
      if (ser_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL after_reset cycle%0d: got valid=%b busy=%b ready=%b expected 0,0,1",
                 c, ser_valid[0], busy[0], in_ready[0]);
      end
    end
    checks++;
    if (saw_last) begin
      errors++; $display("FAIL discarded_last: got ser_last seen expected none");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data[i]   = '0;
      in_valid[i]  = 1'b0;
      ser_ready[i] = 1'b0;
    end
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_lsb_first();
    test_msb_first();
    test_div4();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
